ifetch_ir: RTL and testbench
============================

// Module: ifetch_ir
// PURPOSE
//  Instruction fetch and instruction register stage feeding the microcoded control unit (UC).
//  On a fetch command from the control store, it reads one word from instruction memory over a
//  valid/ready request and valid response interface, then latches that word into IR.
//  It drives opcode[6:0] and the packed register fields r[14:0] that UC decodes. It owns PC.
// PARAMETERS
//  XLEN      32            PC / address width
//  RESET_PC  32'h0000_0000 PC value after reset
//  TIMEOUT   16            max cycles in WAIT before fetch error (>=2)
// PORTS
//  clk             in   1     clock, all state updates on posedge
//  rst             in   1     reset, asynchronous, active-high
//  fetch_start     in   1     UC enable: fetch instruction at PC
//  pc_we           in   1     UC enable: load PC from pc_next
//  pc_next         in   XLEN  branch/jump target from datapath
//  imem_req_valid  out  1     memory request valid
//  imem_req_ready  in   1     memory accepts request
//  imem_addr       out  XLEN  request address (= PC)
//  imem_rsp_valid  in   1     read data valid (one pulse per accepted request)
//  imem_rdata      in   32    instruction word
//  ir              out  32    instruction register
//  opcode          out  7     ir[6:0]
//  r               out  15    {rd=ir[11:7], rs1=ir[19:15], rs2=ir[24:20]}, r[14:10]=rd
//  pc              out  XLEN  next fetch address
//  pc_cur          out  XLEN  address of the instruction held in IR
//  ir_valid        out  1     IR holds a freshly fetched instruction
//  fetch_busy      out  1     state is REQ or WAIT
//  fetch_err       out  1     sticky: misaligned PC or response timeout
// BEHAVIOUR
//  Reset values (asynchronous): state=IDLE, pc=RESET_PC, pc_cur=RESET_PC, ir=NOP (32'h0000_0013),
//  ir_valid=0, fetch_err=0, imem_req_valid=0, timeout count=0, pending PC load cleared.
//  If reset asserts mid-transaction, imem_req_valid drops immediately.
//  Any late response after reset is ignored.
//  FSM states are IDLE, REQ, WAIT and ERR.
//  IDLE:
//   - pc_we=1 loads pc<=pc_next.
//   - If fetch_start=1 in the same cycle, the fetch uses pc_next, not the old PC.
//   - fetch_start=1 clears ir_valid.
//   - fetch_start=1 with the fetch address[1:0]!=0 -> ERR, and no request is issued.
//     Otherwise -> REQ.
//  REQ:
//   - imem_req_valid=1 and imem_addr=pc.
//   - Both must stay stable until imem_req_ready=1.
//   - Handshake cycle -> WAIT, timeout count reset to 0.
//  WAIT:
//   - imem_rsp_valid=1 -> ir<=imem_rdata, pc_cur<=pc, ir_valid<=1, state -> IDLE.
//   - PC update on the same edge: pc<=pc+4, or pc<=pending target if a load is pending.
//   - Without a response, the count increments each cycle.
//     At TIMEOUT-1 with no response -> ERR.
//  ERR: fetch_err=1 and no requests are issued. Leaving ERR requires rst.
//  Busy-state rules:
//   - pc_we=1 in REQ or WAIT does not change the in-flight address.
//     pc_next is captured as a pending target; the last write wins.
//   - fetch_start in REQ, WAIT or ERR is ignored.
//   - imem_rsp_valid outside WAIT is ignored, and ir is unchanged.
//  Latency: with ready in the first REQ cycle and rsp in the next cycle, the path is
//  fetch_start(IDLE) -> REQ -> WAIT -> IDLE with ir_valid=1. That is 3 edges after fetch_start.
//  Arithmetic: pc+4 is modulo 2^XLEN, so 32'hFFFF_FFFC wraps to 0 without error.
//  Outputs: opcode, r and fetch_busy are combinational from registered state/IR.
//  imem_req_valid is decoded from state==REQ.
// STRUCTURE
//  mypack additions: fetch_state_t enum {IDLE,REQ,WAIT,ERR}, localparam NOP_INSN=32'h0000_0013,
//  and field-position constants (OPC_LSB=0, RD_LSB=7, RS1_LSB=15, RS2_LSB=20).
//  Single flat module with no sub-module; the timeout counter and field slicing stay inline.
// TESTING
//  1. Reset -> ir=32'h13, opcode=7'h13, pc=0, ir_valid=0, req_valid=0.
//     fetch_start, ready and rsp immediate, rdata=32'h00A28293 -> ir_valid=1 after 3 edges,
//     opcode=7'h13, r={5'd5,5'd5,5'd10}, pc=4, pc_cur=0.
//  2. Ready held low 5 cycles -> req_valid and addr stay stable for all 5 cycles.
//     Exactly one transaction occurs.
//  3. pc_we with pc_next=32'h100 during WAIT -> the in-flight address is unchanged.
//     After rsp, pc=32'h100 (not old+4).
//  4. pc_we with pc_next=32'h202 and fetch_start in the same IDLE cycle -> ERR, fetch_err=1,
//     and req_valid is never asserted.
//  5. No rsp for TIMEOUT=16 cycles -> ERR on the 16th WAIT cycle.
//     A later rsp and fetch_start are ignored; fetch_err clears only on rst.
//  6. rst pulsed while in REQ -> req_valid=0 immediately and all outputs at reset values.
//     Also check that pc=32'hFFFF_FFFC wraps to 0 after a fetch.

Source files
------------

// File: rtl/ifetch_ir_pkg.sv
// Shared types and constants for the instruction fetch / IR stage.
// Field positions follow the RV32 base encoding that the control unit decodes.
package ifetch_ir_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      REQ  = 2'd1,
      WAIT = 2'd2,
      ERR  = 2'd3
   } fetch_state_t;

   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

   localparam int OPC_LSB = 0;
   localparam int RD_LSB  = 7;
   localparam int RS1_LSB = 15;
   localparam int RS2_LSB = 20;

   // Packed so that rd lands in the top bits of the 15-bit register bundle.
   typedef struct packed {
      logic [4:0] rd;
      logic [4:0] rs1;
      logic [4:0] rs2;
   } reg_fields_t;

   function automatic logic [6:0] insn_opcode(input logic [31:0] insn);
      return insn[OPC_LSB +: 7];
   endfunction

   function automatic reg_fields_t insn_regs(input logic [31:0] insn);
      reg_fields_t f;
      f.rd  = insn[RD_LSB  +: 5];
      f.rs1 = insn[RS1_LSB +: 5];
      f.rs2 = insn[RS2_LSB +: 5];
      return f;
   endfunction

endpackage

// File: rtl/ifetch_ir.sv
// Instruction fetch + instruction register: owns PC, issues one valid/ready read per fetch
// command, latches the returned word into IR and exposes opcode/register fields to the UC.
module ifetch_ir
   import ifetch_ir_pkg::*;
#(
   parameter int              XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0,
   parameter int              TIMEOUT  = 16
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            fetch_start,
   input  logic            pc_we,
   input  logic [XLEN-1:0] pc_next,
   output logic            imem_req_valid,
   input  logic            imem_req_ready,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_rsp_valid,
   input  logic [31:0]     imem_rdata,
   output logic [31:0]     ir,
   output logic [6:0]      opcode,
   output logic [14:0]     r,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_cur,
   output logic            ir_valid,
   output logic            fetch_busy,
   output logic            fetch_err
);

   localparam int              CNT_W    = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   fetch_state_t    state_q;
   logic [XLEN-1:0] pc_q;
   logic [XLEN-1:0] pc_cur_q;
   logic [31:0]     ir_q;
   logic            ir_valid_q;
   logic            err_q;
   logic [CNT_W-1:0] cnt_q;
   logic            pend_valid_q;
   logic [XLEN-1:0] pend_pc_q;

   logic [XLEN-1:0] fetch_addr_d;
   logic            misaligned_d;
   logic [XLEN-1:0] pc_d;

   // A same-cycle pc_we redirects the fetch that fetch_start launches.
   assign fetch_addr_d = pc_we ? pc_next : pc_q;
   assign misaligned_d = |fetch_addr_d[1:0];

   // Next PC once the in-flight fetch completes; the newest redirect wins over sequential flow.
   always_comb begin
      // NOTE: default first so every path assigns pc_d and no latch is inferred.
      pc_d = pc_q + XLEN'(4);
      if (pc_we) begin
         pc_d = pc_next;
      end else if (pend_valid_q) begin
         pc_d = pend_pc_q;
      end
   end

   // NOTE: sequential state uses non-blocking assignments only, so later writes in the block
   // (e.g. clearing the pending target on a response) override earlier ones on the same edge.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q      <= IDLE;
         pc_q         <= RESET_PC;
         pc_cur_q     <= RESET_PC;
         ir_q         <= NOP_INSN;
         ir_valid_q   <= 1'b0;
         err_q        <= 1'b0;
         cnt_q        <= '0;
         pend_valid_q <= 1'b0;
         pend_pc_q    <= RESET_PC;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (pc_we) begin
                  pc_q <= pc_next;
               end
               if (fetch_start) begin
                  ir_valid_q <= 1'b0;
                  if (misaligned_d) begin
                     state_q <= ERR;
                     err_q   <= 1'b1;
                  end else begin
                     state_q <= REQ;
                  end
               end
            end

            REQ: begin
               if (pc_we) begin
                  pend_valid_q <= 1'b1;
                  pend_pc_q    <= pc_next;
               end
               if (imem_req_ready) begin
                  state_q <= WAIT;
                  cnt_q   <= '0;
               end
            end

            WAIT: begin
               if (imem_rsp_valid) begin
                  ir_q         <= imem_rdata;
                  pc_cur_q     <= pc_q;
                  ir_valid_q   <= 1'b1;
                  pc_q         <= pc_d;
                  pend_valid_q <= 1'b0;
                  state_q      <= IDLE;
               end else begin
                  if (pc_we) begin
                     pend_valid_q <= 1'b1;
                     pend_pc_q    <= pc_next;
                  end
                  if (cnt_q == CNT_LAST) begin
                     state_q <= ERR;
                     err_q   <= 1'b1;
                  end else begin
                     cnt_q <= cnt_q + 1'b1;
                  end
               end
            end

            ERR: begin
               err_q <= 1'b1;
            end

            default: begin
               state_q <= ERR;
               err_q   <= 1'b1;
            end
         endcase
      end
   end

   // Request valid is a pure state decode so an async reset drops it without waiting for clk.
   assign imem_req_valid = (state_q == REQ);
   assign imem_addr      = pc_q;
   assign fetch_busy     = (state_q == REQ) || (state_q == WAIT);
   assign fetch_err      = err_q;

   assign ir       = ir_q;
   assign opcode   = insn_opcode(ir_q);
   assign r        = insn_regs(ir_q);
   assign pc       = pc_q;
   assign pc_cur   = pc_cur_q;
   assign ir_valid = ir_valid_q;

endmodule

// File: tb/tb_ifetch_ir.sv
// Directed bench for ifetch_ir: a per-cycle vector table for the main fetch flow plus
// hand-written sequences for stalls, misalignment, timeout, async reset and PC wrap.
module tb_ifetch_ir;
   import ifetch_ir_pkg::*;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        fetch_start = 1'b0;
   logic        pc_we = 1'b0;
   logic [31:0] pc_next = '0;
   logic        imem_req_valid;
   logic        imem_req_ready = 1'b0;
   logic [31:0] imem_addr;
   logic        imem_rsp_valid = 1'b0;
   logic [31:0] imem_rdata = '0;
   logic [31:0] ir;
   logic [6:0]  opcode;
   logic [14:0] r;
   logic [31:0] pc;
   logic [31:0] pc_cur;
   logic        ir_valid;
   logic        fetch_busy;
   logic        fetch_err;

   int n_checks = 0;
   int n_errors = 0;
   int hs_cnt   = 0;
   int req_cnt  = 0;

   ifetch_ir #(.XLEN(32), .RESET_PC(32'h0000_0000), .TIMEOUT(16)) dut (
      .clk            (clk),
      .rst            (rst),
      .fetch_start    (fetch_start),
      .pc_we          (pc_we),
      .pc_next        (pc_next),
      .imem_req_valid (imem_req_valid),
      .imem_req_ready (imem_req_ready),
      .imem_addr      (imem_addr),
      .imem_rsp_valid (imem_rsp_valid),
      .imem_rdata     (imem_rdata),
      .ir             (ir),
      .opcode         (opcode),
      .r              (r),
      .pc             (pc),
      .pc_cur         (pc_cur),
      .ir_valid       (ir_valid),
      .fetch_busy     (fetch_busy),
      .fetch_err      (fetch_err)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (imem_req_valid && imem_req_ready) hs_cnt++;
      if (imem_req_valid) req_cnt++;
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   typedef struct {
      logic        fs;
      logic        we;
      logic [31:0] nxt;
      logic        rdy;
      logic        rsp;
      logic [31:0] rdata;
      logic        e_req;
      logic        e_busy;
      logic        e_irv;
      logic        e_err;
      logic [31:0] e_pc;
      logic [31:0] e_pc_cur;
      logic [31:0] e_ir;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic fs, input logic we, input logic [31:0] nxt,
                               input logic rdy, input logic rsp, input logic [31:0] rdata,
                               input logic e_req, input logic e_busy, input logic e_irv,
                               input logic e_err, input logic [31:0] e_pc,
                               input logic [31:0] e_pc_cur, input logic [31:0] e_ir);
      vec_t v;
      v.fs = fs; v.we = we; v.nxt = nxt; v.rdy = rdy; v.rsp = rsp; v.rdata = rdata;
      v.e_req = e_req; v.e_busy = e_busy; v.e_irv = e_irv; v.e_err = e_err;
      v.e_pc = e_pc; v.e_pc_cur = e_pc_cur; v.e_ir = e_ir;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Drive one cycle of inputs, then sample just after the next rising edge.
   task automatic step(input logic fs, input logic we, input logic [31:0] nxt,
                       input logic rdy, input logic rsp, input logic [31:0] rdata);
      fetch_start    = fs;
      pc_we          = we;
      pc_next        = nxt;
      imem_req_ready = rdy;
      imem_rsp_valid = rsp;
      imem_rdata     = rdata;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      fetch_start = 1'b0; pc_we = 1'b0; pc_next = '0;
      imem_req_ready = 1'b0; imem_rsp_valid = 1'b0; imem_rdata = '0;
   endtask

   task automatic do_reset();
      idle_inputs();
      rst = 1'b1;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic check_reset_state(input string tag);
      check({tag, " ir"},        ir, NOP_INSN);
      check({tag, " opcode"},    {25'b0, opcode}, 32'h13);
      check({tag, " pc"},        pc, 32'h0);
      check({tag, " pc_cur"},    pc_cur, 32'h0);
      check({tag, " ir_valid"},  {31'b0, ir_valid}, 32'h0);
      check({tag, " req_valid"}, {31'b0, imem_req_valid}, 32'h0);
      check({tag, " busy"},      {31'b0, fetch_busy}, 32'h0);
      check({tag, " err"},       {31'b0, fetch_err}, 32'h0);
   endtask

   initial begin
      int hs_base;
      int req_base;

      vecs.push_back(mk(1,0,32'h0,  0,0,32'h0,        1,1,0,0, 32'h0,   32'h0,   NOP_INSN));
      vecs.push_back(mk(0,0,32'h0,  1,0,32'h0,        0,1,0,0, 32'h0,   32'h0,   NOP_INSN));
      vecs.push_back(mk(0,0,32'h0,  0,1,32'h00A28293, 0,0,1,0, 32'h4,   32'h0,   32'h00A28293));
      vecs.push_back(mk(1,0,32'h0,  0,0,32'h0,        1,1,0,0, 32'h4,   32'h0,   32'h00A28293));
      vecs.push_back(mk(0,1,32'h200,0,0,32'h0,        1,1,0,0, 32'h4,   32'h0,   32'h00A28293));
      vecs.push_back(mk(0,0,32'h0,  1,0,32'h0,        0,1,0,0, 32'h4,   32'h0,   32'h00A28293));
      vecs.push_back(mk(0,1,32'h100,0,0,32'h0,        0,1,0,0, 32'h4,   32'h0,   32'h00A28293));
      vecs.push_back(mk(0,0,32'h0,  0,1,32'h00500093, 0,0,1,0, 32'h100, 32'h4,   32'h00500093));
      vecs.push_back(mk(0,0,32'h0,  0,1,32'hDEADBEEF, 0,0,1,0, 32'h100, 32'h4,   32'h00500093));
      vecs.push_back(mk(1,1,32'h300,0,0,32'h0,        1,1,0,0, 32'h300, 32'h4,   32'h00500093));
      vecs.push_back(mk(0,0,32'h0,  1,1,32'hCAFEF00D, 0,1,0,0, 32'h300, 32'h4,   32'h00500093));
      vecs.push_back(mk(0,0,32'h0,  0,1,32'h00000033, 0,0,1,0, 32'h304, 32'h300, 32'h00000033));

      // Reset state and table-driven fetch flow.
      do_reset();
      check_reset_state("reset");
      foreach (vecs[i]) begin
         vec_t v;
         string tag;
         v = vecs[i];
         tag = $sformatf("vec%0d", i);
         step(v.fs, v.we, v.nxt, v.rdy, v.rsp, v.rdata);
         check({tag, " req_valid"}, {31'b0, imem_req_valid}, {31'b0, v.e_req});
         check({tag, " busy"},      {31'b0, fetch_busy},     {31'b0, v.e_busy});
         check({tag, " ir_valid"},  {31'b0, ir_valid},       {31'b0, v.e_irv});
         check({tag, " err"},       {31'b0, fetch_err},      {31'b0, v.e_err});
         check({tag, " pc"},        pc,     v.e_pc);
         check({tag, " pc_cur"},    pc_cur, v.e_pc_cur);
         check({tag, " ir"},        ir,     v.e_ir);
         if (v.e_req) check({tag, " addr"}, imem_addr, v.e_pc);
         if (i == 2) begin
            check("t1 opcode", {25'b0, opcode}, 32'h13);
            check("t1 r",      {17'b0, r}, {17'b0, 5'd5, 5'd5, 5'd10});
         end
         if (i == 7) check("t3 r", {17'b0, r}, {17'b0, 5'd1, 5'd0, 5'd5});
         if (i == 11) check("vec11 opcode", {25'b0, opcode}, 32'h33);
      end
      idle_inputs();

      // Request held while ready is low: stable request, exactly one handshake.
      do_reset();
      hs_base = hs_cnt;
      step(1,0,32'h0, 0,0,32'h0);
      for (int k = 0; k < 5; k++) begin
         check($sformatf("stall%0d req_valid", k), {31'b0, imem_req_valid}, 32'h1);
         check($sformatf("stall%0d addr", k), imem_addr, 32'h0);
         step(0,0,32'h0, 0,0,32'h0);
      end
      check("stall req_valid before ready", {31'b0, imem_req_valid}, 32'h1);
      step(0,0,32'h0, 1,0,32'h0);
      check("stall in WAIT req_valid", {31'b0, imem_req_valid}, 32'h0);
      step(0,0,32'h0, 1,1,32'h00000013);
      step(0,0,32'h0, 1,0,32'h0);
      check("stall handshakes", hs_cnt - hs_base, 32'd1);
      check("stall pc", pc, 32'h4);
      check("stall ir_valid", {31'b0, ir_valid}, 32'h1);
      idle_inputs();

      // Misaligned redirect together with fetch_start: error, never a request.
      do_reset();
      req_base = req_cnt;
      step(1,1,32'h202, 1,0,32'h0);
      check("misalign err", {31'b0, fetch_err}, 32'h1);
      check("misalign pc", pc, 32'h202);
      check("misalign busy", {31'b0, fetch_busy}, 32'h0);
      repeat (3) step(1,0,32'h0, 1,1,32'h12345678);
      check("misalign no req", req_cnt - req_base, 32'd0);
      check("misalign err sticky", {31'b0, fetch_err}, 32'h1);
      check("misalign ir", ir, NOP_INSN);
      idle_inputs();

      // Response timeout: ERR on the 16th WAIT cycle, later traffic ignored.
      do_reset();
      step(1,0,32'h0, 0,0,32'h0);
      step(0,0,32'h0, 1,0,32'h0);
      repeat (15) step(0,0,32'h0, 0,0,32'h0);
      check("timeout 15 busy", {31'b0, fetch_busy}, 32'h1);
      check("timeout 15 err", {31'b0, fetch_err}, 32'h0);
      step(0,0,32'h0, 0,0,32'h0);
      check("timeout 16 err", {31'b0, fetch_err}, 32'h1);
      check("timeout 16 busy", {31'b0, fetch_busy}, 32'h0);
      req_base = req_cnt;
      step(0,0,32'h0, 1,1,32'h12345678);
      step(1,0,32'h0, 1,1,32'h12345678);
      step(0,0,32'h0, 1,0,32'h0);
      check("timeout late ir", ir, NOP_INSN);
      check("timeout late ir_valid", {31'b0, ir_valid}, 32'h0);
      check("timeout no req", req_cnt - req_base, 32'd0);
      check("timeout err sticky", {31'b0, fetch_err}, 32'h1);
      do_reset();
      check("timeout err cleared", {31'b0, fetch_err}, 32'h0);

      // Async reset in REQ drops the request before any clock edge; late response ignored.
      step(1,1,32'h40, 0,0,32'h0);
      check("arst pre req_valid", {31'b0, imem_req_valid}, 32'h1);
      #2;
      rst = 1'b1;
      #1;
      check_reset_state("arst");
      step(0,0,32'h0, 0,1,32'hDEADBEEF);
      @(negedge clk);
      rst = 1'b0;
      step(0,0,32'h0, 0,1,32'hDEADBEEF);
      check("arst late rsp ir", ir, NOP_INSN);
      check("arst late rsp ir_valid", {31'b0, ir_valid}, 32'h0);

      // PC wraps modulo 2^32 after fetching from the last word.
      step(1,1,32'hFFFF_FFFC, 0,0,32'h0);
      check("wrap addr", imem_addr, 32'hFFFF_FFFC);
      step(0,0,32'h0, 1,0,32'h0);
      step(0,0,32'h0, 0,1,32'h00000013);
      check("wrap pc", pc, 32'h0);
      check("wrap pc_cur", pc_cur, 32'hFFFF_FFFC);
      check("wrap err", {31'b0, fetch_err}, 32'h0);
      check("wrap ir_valid", {31'b0, ir_valid}, 32'h1);
      idle_inputs();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
